// File: rtl/ghr_spec_ctrl.sv
// ghr_spec_ctrl
// Speculative global-history register controller for the branch predictor.
// Every accepted fetch prediction shifts the history. The pre-shift history
// is checkpointed into an in-order FIFO, one entry per in-flight branch. A
// mispredicted resolve of the oldest branch rebuilds the history from its
// checkpoint plus the actual outcome, flushes the FIFO, and spends one
// RECOVER cycle during which new predictions are refused.
//
// Ports:
//   CLK            clock
//   nRST           asynchronous active-low reset
//   pred_valid     fetch presents a conditional-branch prediction
//   pred_taken     predicted direction
//   pred_ready     prediction can be accepted this cycle (registered state only)
//   res_valid      oldest in-flight branch resolves
//   res_taken      actual direction
//   res_mispredict actual direction differs from prediction
//   ghr            speculative history (registered)
//   ckpt_count     occupied checkpoint entries, 0..DEPTH
//   recovering     high for the single recovery cycle
//   err            (only with GHR_SPEC_ERR_EN) sticky protocol-error flag
//
// Optional build macro: GHR_SPEC_ERR_EN adds the err output, set the cycle
// after a resolve on an empty FIFO in RUN or a prediction offered while full.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal operation, predictions accepted when FIFO not full
// RECOVER | one-cycle bubble after a mispredict, FIFO empty, no accept

module ghr_spec_ctrl #(
    parameter int GHR_W = 3,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic                     res_mispredict,
    output logic [GHR_W-1:0]         ghr,
    output logic [$clog2(DEPTH):0]   ckpt_count,
    output logic                     recovering
`ifdef GHR_SPEC_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Only the low GHR_W-1 bits of a checkpoint are ever used: recovery
    // shifts the checkpoint left by one and drops its MSB.
    logic [GHR_W-2:0] ckpt_mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [GHR_W-2:0] head_ckpt;

    logic             pop;
    logic             mis_pop;
    logic             push;
    logic [CNT_W-1:0] count_nxt;
    logic [GHR_W-1:0] ghr_nxt;
    logic [PTR_W-1:0] head_nxt, tail_nxt;

    assign head_ckpt = ckpt_mem[head];

    // Event decode. A mispredict pop squashes any same-cycle push because
    // that prediction belongs to the wrong path.
    always_comb begin
        pop     = res_valid && (ckpt_count != '0) && (state == RUN);
        mis_pop = pop && res_mispredict;
        push    = pred_valid && pred_ready && !mis_pop;
    end

    // Datapath next values.
    always_comb begin
        count_nxt = ckpt_count;
        ghr_nxt   = ghr;
        head_nxt  = head;
        tail_nxt  = tail;
        if (mis_pop) begin
            count_nxt = '0;
            head_nxt  = '0;
            tail_nxt  = '0;
            ghr_nxt   = {head_ckpt, res_taken};
        end else begin
            if (pop) begin
                head_nxt = head + PTR_W'(1);
            end
            if (push) begin
                tail_nxt = tail + PTR_W'(1);
                ghr_nxt  = {ghr[GHR_W-2:0], pred_taken};
            end
            case ({push, pop})
                2'b10:   count_nxt = ckpt_count + CNT_W'(1);
                2'b01:   count_nxt = ckpt_count - CNT_W'(1);
                default: count_nxt = ckpt_count;
            endcase
        end
    end

    // FSM: state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mis_pop) state_nxt = RECOVER;
            RECOVER: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM: outputs. pred_ready looks only at registered state so a pop in a
    // full cycle cannot open the door until the following cycle.
    always_comb begin
        pred_ready = (state == RUN) && (ckpt_count != FULL);
        recovering = (state == RECOVER);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ghr        <= '0;
            ckpt_count <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            ghr        <= ghr_nxt;
            ckpt_count <= count_nxt;
            head       <= head_nxt;
            tail       <= tail_nxt;
        end
    end

    // Checkpoint storage needs no reset; entries are only read once written.
    always_ff @(posedge CLK) begin
        if (push) begin
            ckpt_mem[tail] <= ghr[GHR_W-2:0];
        end
    end

`ifdef GHR_SPEC_ERR_EN
    logic err_evt;
    assign err_evt = (res_valid && (ckpt_count == '0) && (state == RUN)) ||
                     (pred_valid && (ckpt_count == FULL));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err <= 1'b0;
        end else if (err_evt) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ghr_spec_ctrl.sv
module tb_ghr_spec_ctrl;

    localparam int GHR_W = 3;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << GHR_W) - 1;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       pred_valid = 1'b0;
    logic       pred_taken = 1'b0;
    logic       pred_ready;
    logic       res_valid = 1'b0;
    logic       res_taken = 1'b0;
    logic       res_mispredict = 1'b0;
    logic [GHR_W-1:0] ghr;
    logic [$clog2(DEPTH):0] ckpt_count;
    logic       recovering;
`ifdef GHR_SPEC_ERR_EN
    logic       err;
`endif

    ghr_spec_ctrl #(.GHR_W(GHR_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .res_mispredict(res_mispredict),
        .ghr(ghr),
        .ckpt_count(ckpt_count),
        .recovering(recovering)
`ifdef GHR_SPEC_ERR_EN
        ,
        .err(err)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: history as an integer, checkpoints as a queue.
    int m_ghr = 0;
    int m_q[$];
    bit m_rec = 0;
    bit m_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ghr"}, int'(ghr), m_ghr);
        chk({tag, ".count"}, int'(ckpt_count), m_q.size());
        chk({tag, ".recovering"}, int'(recovering), int'(m_rec));
        chk({tag, ".ready"}, int'(pred_ready), int'(!m_rec && m_q.size() != DEPTH));
`ifdef GHR_SPEC_ERR_EN
        chk({tag, ".err"}, int'(err), int'(m_err));
`endif
    endtask

    task automatic model_reset();
        m_ghr = 0;
        m_q.delete();
        m_rec = 0;
        m_err = 0;
    endtask

    // Called just after a posedge (+1). Drives one cycle of inputs, advances
    // model and DUT by one edge, and compares afterwards.
    task automatic step(input bit pv, input bit pt, input bit rv,
                        input bit rt, input bit rm, input string tag);
        bit ready, pop, mis, push;
        pred_valid = pv; pred_taken = pt;
        res_valid = rv; res_taken = rt; res_mispredict = rm;
        ready = !m_rec && (m_q.size() != DEPTH);
        #1;
        chk({tag, ".ready_pre"}, int'(pred_ready), int'(ready));
        pop  = rv && m_q.size() != 0 && !m_rec;
        mis  = pop && rm;
        push = pv && ready && !mis;
        if ((rv && m_q.size() == 0 && !m_rec) || (pv && m_q.size() == DEPTH))
            m_err = 1;
        if (mis) begin
            m_ghr = ((m_q[0] << 1) | int'(rt)) & MASK;
            m_q.delete();
            m_rec = 1;
        end else begin
            m_rec = 0;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(m_ghr);
                m_ghr = ((m_ghr << 1) | int'(pt)) & MASK;
            end
        end
        @(posedge CLK);
        #1;
        pred_valid = 0; res_valid = 0; res_mispredict = 0;
        chk_all(tag);
    endtask

    task automatic do_reset();
        nRST = 0;
        pred_valid = 0; res_valid = 0; res_mispredict = 0;
        model_reset();
        #1;
        chk_all("reset");
        @(posedge CLK);
        #2;
        nRST = 1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset.
        do_reset();
        chk("reset.ghr_const", int'(ghr), 0);
        chk("reset.ready_const", int'(pred_ready), 1);

        // Push T,N,T.
        step(1, 1, 0, 0, 0, "push1");
        chk("push1.ghr_const", int'(ghr), 3'b001);
        step(1, 0, 0, 0, 0, "push2");
        chk("push2.ghr_const", int'(ghr), 3'b010);
        step(1, 1, 0, 0, 0, "push3");
        chk("push3.ghr_const", int'(ghr), 3'b101);
        chk("push3.count_const", int'(ckpt_count), 3);

        // Correct resolve then mispredict taken (head ckpt 001).
        step(0, 0, 1, 0, 0, "res_ok");
        chk("res_ok.count_const", int'(ckpt_count), 2);
        chk("res_ok.ghr_const", int'(ghr), 3'b101);
        step(0, 0, 1, 1, 1, "res_mis");
        chk("res_mis.ghr_const", int'(ghr), 3'b011);
        chk("res_mis.rec_const", int'(recovering), 1);
        chk("res_mis.ready_const", int'(pred_ready), 0);
        step(1, 1, 1, 0, 0, "in_recover");
        chk("in_recover.ghr_const", int'(ghr), 3'b011);
        chk("after_rec.ready_const", int'(pred_ready), 1);

        // Fill to full, then a 5th prediction with a pop in the same cycle.
        for (int i = 0; i < 4; i++) step(1, i[0], 0, 0, 0, "fill");
        chk("full.count_const", int'(ckpt_count), 4);
        chk("full.ready_const", int'(pred_ready), 0);
        step(1, 1, 0, 0, 0, "fifth");
        step(1, 1, 1, 0, 0, "full_pop");
        chk("full_pop.count_const", int'(ckpt_count), 3);

        // Simultaneous push + correct pop, then push + mispredict pop.
        step(0, 0, 1, 0, 0, "to2");
        step(1, 1, 1, 0, 0, "sim_ok");
        chk("sim_ok.count_const", int'(ckpt_count), 2);
        step(1, 1, 1, 0, 1, "sim_mis");
        chk("sim_mis.count_const", int'(ckpt_count), 0);

        // Reset in the RECOVER cycle.
        nRST = 0;
        model_reset();
        #1;
        chk_all("rst_in_recover");
        #2;
        nRST = 1;
        @(posedge CLK);
        #1;
        step(0, 0, 1, 1, 1, "res_empty");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
